// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and
// the parameter legality rule used by the top level.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // WIDTH must be at least 2 and split into whole DIGIT-bit digits.
  function automatic bit params_legal(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result port bundle of the serial subtractor; the master side
// supplies operands and consumes results, the slave side is the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  // A transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only while idle; out_valid stays high with diff and
  // flags stable until out_ready accepts the result.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, abort, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, abort, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf
  );

endinterface

// File: rtl/serial_subtractor_fs_digit.sv
// DIGIT-wide combinational ripple of full-subtractor cells:
// {bo, d} = x - y - bi.
module fs_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic c;

  always_comb begin
    c = bi;
    d = '0;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = x[i] ^ y[i] ^ c;
      c    = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & c);
    end
    bo = c;
  end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock,
// with registered borrow-out, zero and signed-overflow flags.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus,
  output state_e               dbg_state
);

  localparam int NSTEP = WIDTH / DIGIT;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  generate
    if (!params_legal(WIDTH, DIGIT)) begin : g_bad_params
      $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  state_e           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             brw;
  logic             a_msb;
  logic             b_msb;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0]       d;
  logic                   bo;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_nxt;

  fs_digit #(.DIGIT(DIGIT)) u_cell (
    .x  (a_sr[DIGIT-1:0]),
    .y  (b_sr[DIGIT-1:0]),
    .bi (brw),
    .d  (d),
    .bo (bo)
  );

  // New digit enters at the MSB end; after NSTEP shifts the first digit is at bit 0.
  assign res_cat = {d, res};
  assign res_nxt = res_cat[WIDTH+DIGIT-1:DIGIT];

  assign bus.in_ready = (state == IDLE);
  assign dbg_state    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_sr          <= '0;
      b_sr          <= '0;
      res           <= '0;
      brw           <= 1'b0;
      a_msb         <= 1'b0;
      b_msb         <= 1'b0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.diff      <= '0;
      bus.bout      <= 1'b0;
      bus.zero      <= 1'b0;
      bus.ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && !bus.abort) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            brw   <= bus.bin;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end else begin
            res  <= res_nxt;
            a_sr <= a_sr >> DIGIT;
            b_sr <= b_sr >> DIGIT;
            brw  <= bo;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(NSTEP - 1)) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.diff      <= res_nxt;
              bus.bout      <= bo;
              bus.zero      <= (res_nxt == '0);
              // Signed overflow: operands differ in sign and result sign differs from a.
              bus.ovf       <= (a_msb ^ b_msb) & (a_msb ^ res_nxt[WIDTH-1]);
            end
          end
        end
        DONE: begin
          if (bus.abort || bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed cases on an 8-bit/1-bit instance and
// randomized traffic on a 16-bit/4-bit instance against an arithmetic model.
module tb_serial_subtractor;
  import sub_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8))  bus8();
  serial_subtractor_if #(.WIDTH(16)) bus16();
  state_e st8;
  state_e st16;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus8),
    .dbg_state (st8)
  );

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus16),
    .dbg_state (st16)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Packed result: diff in [15:0], bout [16], zero [17], ovf [18].
  function automatic logic [31:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic bin);
    longint ua, ub, raw, sa, sb, sr, half, full;
    logic [31:0] r;
    full = longint'(1) << w;
    half = full / 2;
    ua   = longint'(a);
    ub   = longint'(b);
    raw  = ua - ub - longint'(bin);
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    sr   = sa - sb - longint'(bin);
    r        = '0;
    r[15:0]  = 16'((raw + full) % full);
    r[16]    = (raw < 0);
    r[17]    = (((raw + full) % full) == 0);
    r[18]    = (sr < -half) || (sr > half - 1);
    return r;
  endfunction

  function automatic logic [31:0] obs8();
    return {13'd0, bus8.ovf, bus8.zero, bus8.bout, 8'd0, bus8.diff};
  endfunction

  function automatic logic [31:0] obs16();
    return {13'd0, bus16.ovf, bus16.zero, bus16.bout, bus16.diff};
  endfunction

  // ---------------- driver tasks (8-bit instance) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait for the accept edge, then count edges to out_valid.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output int lat);
    int t;
    bus8.a = a; bus8.b = b; bus8.bin = bin; bus8.in_valid = 1'b1;
    t = 0;
    while (!bus8.in_ready && t < 50) begin tick(); t++; end
    if (t >= 50) check("in_ready_timeout8", 32'(t), 32'd0);
    tick();
    bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 50) begin tick(); lat++; end
  endtask

  task automatic release8();
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
    check("out_valid_drop8", 32'(bus8.out_valid), 32'd0);
    check("in_ready_after8", 32'(bus8.in_ready), 32'd1);
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic bin, input logic [7:0] ed, input logic eb,
                     input logic ez, input logic eo);
    int lat;
    start8(a, b, bin, lat);
    check({tag, "_lat"},  32'(lat),        32'd8);
    check({tag, "_diff"}, 32'(bus8.diff),  32'(ed));
    check({tag, "_bout"}, 32'(bus8.bout),  32'(eb));
    check({tag, "_zero"}, 32'(bus8.zero),  32'(ez));
    check({tag, "_ovf"},  32'(bus8.ovf),   32'(eo));
    check({tag, "_model"}, obs8(), model(8, 32'(a), 32'(b), bin));
    release8();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int seen;
    logic [15:0] ra, rb;
    logic rbin;
    logic [31:0] exp;

    rst_n = 1'b0;
    bus8.in_valid = 0; bus8.a = 0; bus8.b = 0; bus8.bin = 0; bus8.abort = 0; bus8.out_ready = 0;
    bus16.in_valid = 0; bus16.a = 0; bus16.b = 0; bus16.bin = 0; bus16.abort = 0; bus16.out_ready = 0;
    repeat (2) tick();
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_flags", obs8(), 32'd0);
    check("rst_state", 32'(st8), 32'(IDLE));
    rst_n = 1'b1;
    tick();
    check("rel_in_ready8", 32'(bus8.in_ready), 32'd1);
    check("rel_in_ready16", 32'(bus16.in_ready), 32'd1);

    // Basic arithmetic and boundary cases.
    op8("t1",  8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    op8("t2a", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0);
    op8("t2b", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
    op8("t3a", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    op8("t3b", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    op8("t3c", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1);

    // Stall in DONE while in_valid toggles with different operands.
    start8(8'h80, 8'h01, 1'b0, lat);
    check("stall_lat", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      bus8.in_valid = i[0];
      bus8.a = 8'($urandom_range(0, 255));
      tick();
      check("stall_diff", 32'(bus8.diff), 32'h7F);
      check("stall_ovf", 32'(bus8.ovf), 32'd1);
      check("stall_out_valid", 32'(bus8.out_valid), 32'd1);
      check("stall_in_ready", 32'(bus8.in_ready), 32'd0);
    end
    bus8.in_valid = 1'b0;
    release8();
    tick();
    check("stall_no_accept", 32'(st8), 32'(IDLE));
    check("hold_diff_idle", 32'(bus8.diff), 32'h7F);

    // Asynchronous reset on the third RUN cycle.
    bus8.a = 8'h55; bus8.b = 8'h11; bus8.bin = 0; bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    repeat (2) tick();
    check("pre_rst_state", 32'(st8), 32'(RUN));
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("midrst_diff", 32'(bus8.diff), 32'd0);
    check("midrst_state", 32'(st8), 32'(IDLE));
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_in_ready", 32'(bus8.in_ready), 32'd1);
    op8("post_rst", 8'h55, 8'h11, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0);

    // Abort during RUN.
    bus8.a = 8'h20; bus8.b = 8'h01; bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    tick();
    bus8.abort = 1'b1;
    tick();
    bus8.abort = 1'b0;
    check("abort_run_state", 32'(st8), 32'(IDLE));
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus8.out_valid) seen++;
    end
    check("abort_run_no_valid", 32'(seen), 32'd0);

    // Abort in DONE.
    start8(8'h09, 8'h04, 1'b0, lat);
    check("abort_done_lat", 32'(lat), 32'd8);
    bus8.abort = 1'b1;
    tick();
    bus8.abort = 1'b0;
    check("abort_done_valid", 32'(bus8.out_valid), 32'd0);
    check("abort_done_state", 32'(st8), 32'(IDLE));

    // Abort in IDLE blocks acceptance, then the held request goes through.
    bus8.a = 8'h40; bus8.b = 8'h41; bus8.bin = 1'b1; bus8.in_valid = 1'b1; bus8.abort = 1'b1;
    tick();
    check("abort_idle_block", 32'(st8), 32'(IDLE));
    bus8.abort = 1'b0;
    tick();
    bus8.in_valid = 1'b0;
    check("abort_idle_accept", 32'(st8), 32'(RUN));
    lat = 0;
    while (!bus8.out_valid && lat < 50) begin tick(); lat++; end
    check("abort_idle_lat", 32'(lat), 32'd8);
    check("abort_idle_res", obs8(), model(8, 32'h40, 32'h41, 1'b1));
    release8();

    // Randomized traffic on the 16-bit / 4-bit-digit instance.
    for (int n = 0; n < 2000; n++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rbin = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) ra = (n % 2 == 0) ? 16'h8000 : 16'hFFFF;
      if ($urandom_range(0, 7) == 0) rb = (n % 3 == 0) ? 16'h7FFF : 16'h0000;
      repeat ($urandom_range(0, 2)) tick();
      bus16.a = ra; bus16.b = rb; bus16.bin = rbin; bus16.in_valid = 1'b1;
      seen = 0;
      while (!bus16.in_ready && seen < 50) begin tick(); seen++; end
      if (seen >= 50) check("rnd_in_ready_timeout", 32'(seen), 32'd0);
      tick();
      bus16.in_valid = 1'b0;
      exp_q.push_back(model(16, 32'(ra), 32'(rb), rbin));
      lat = 0;
      while (!bus16.out_valid && lat < 50) begin tick(); lat++; end
      check("rnd_lat", 32'(lat), 32'd4);
      repeat ($urandom_range(0, 3)) begin
        bus16.in_valid = 1'($urandom_range(0, 1));
        tick();
        check("rnd_stall_valid", 32'(bus16.out_valid), 32'd1);
      end
      bus16.in_valid = 1'b0;
      exp = exp_q.pop_front();
      check("rnd_result", obs16(), exp);
      bus16.out_ready = 1'b1;
      tick();
      bus16.out_ready = 1'b0;
      check("rnd_drop", 32'(bus16.out_valid), 32'd0);
    end
    check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
